dadda_mac_acc: RTL and testbench

Downstream accumulate stage for the pipelined 16x16 signed Dadda multiplier. Consumes the registered 32-bit product, re-aligns the operand-side valid/last qualifiers through a delay line matching the multiplier latency, and sums signed products into a wide accumulator. At each group end it presents the dot-product result on a valid/ready output port. Turns the multiplier into a streaming MAC engine.

---
 rtl/dadda_mac_acc.sv | 151 +++++++++++++++
 tb/tb_dadda_mac_acc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mac_acc.sv
// Streaming accumulate stage behind the pipelined 16x16 Dadda multiplier: realigns valid/last with the product and sums groups.
// Optional macro DADDA_MAC_SAT_EN selects a saturating accumulator; without it the sum wraps and only the overflow is flagged.
module dadda_mac_acc #(
    parameter int LATENCY = 10,
    parameter int PROD_W  = 32,
    parameter int ACC_W   = 40,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic signed [PROD_W-1:0] prod,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_ovf,
    output logic                     overrun,
    output logic                     busy
);

    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W-1:0] s;
        s = a + b;
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    function automatic logic signed [ACC_W-1:0] add_res(input logic signed [ACC_W-1:0] a,
                                                         input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W-1:0] s;
        s = a + b;
`ifdef DADDA_MAC_SAT_EN
        if (add_ovf(a, b)) s = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
`endif
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    state_t                  state_q, state_d;
    logic [LATENCY-1:0]      vld_sr_q, vld_sr_d, last_sr_q, last_sr_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [CNT_W-1:0]        out_count_q, out_count_d;
    logic                    out_ovf_q, out_ovf_d;
    logic                    overrun_q, overrun_d;

    logic                    a_valid, a_last, done;
    logic signed [ACC_W-1:0] prod_ext, sum;
    logic [CNT_W-1:0]        cnt_nx;
    logic                    ovf_nx;

    assign a_valid  = vld_sr_q[LATENCY-1];
    assign a_last   = last_sr_q[LATENCY-1];
    assign prod_ext = ACC_W'(prod);

    always_comb begin
        vld_sr_d  = (vld_sr_q << 1) | LATENCY'(in_valid);
        last_sr_d = (last_sr_q << 1) | LATENCY'(in_valid & in_last);

        // acc/cnt/ovf are zero in IDLE, so one adder path serves both states
        sum    = add_res(acc_q, prod_ext);
        ovf_nx = ovf_q | add_ovf(acc_q, prod_ext);
        cnt_nx = cnt_inc(cnt_q);

        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        done    = 1'b0;
        if (a_valid) begin
            if (a_last) begin
                done    = 1'b1;
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end else begin
                state_d = ACCUM;
                acc_d   = sum;
                cnt_d   = cnt_nx;
                ovf_d   = ovf_nx;
            end
        end

        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        overrun_d   = overrun_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (done) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_acc_d   = sum;
                out_count_d = cnt_nx;
                out_ovf_d   = ovf_nx;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vld_sr_q    <= '0;
            last_sr_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vld_sr_q    <= vld_sr_d;
            last_sr_q   <= last_sr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == ACCUM) | (|vld_sr_q);

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Directed bench for dadda_mac_acc with a behavioural 10-cycle signed multiplier feeding prod.
module tb_dadda_mac_acc;

    localparam int LAT = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, out_ready;
    logic [31:0] prod;
    logic        out_valid, out_ovf, overrun, busy;
    logic [39:0] out_acc;
    logic [7:0]  out_count;

    logic signed [15:0] a_op, b_op;
    logic signed [31:0] pipe [LAT];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= a_op * b_op;
    end
    assign prod = pipe[LAT-1];

    dadda_mac_acc #(.LATENCY(LAT), .PROD_W(32), .ACC_W(40), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .prod      (prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .overrun   (overrun),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic v, input logic l);
        @(posedge clk);
        #1;
        a_op     = a;
        b_op     = b;
        in_valid = v;
        in_last  = l;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_out(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, {63'd0, out_valid}, 64'd1);
    endtask

    logic seen;
    logic [39:0] big_exp;

    initial begin
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        a_op = '0; b_op = '0;
        cycles(3);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_acc",   {24'd0, out_acc}, 64'd0);
        chk("rst_out_count", {56'd0, out_count}, 64'd0);
        chk("rst_out_ovf",   {63'd0, out_ovf}, 64'd0);
        chk("rst_overrun",   {63'd0, overrun}, 64'd0);
        chk("rst_busy",      {63'd0, busy}, 64'd0);
        rst = 1'b0;
        cycles(2);

        // 3*4 + (-2)*5 + 7*7 = 51, valid rises 11 cycles after the last term
        drive(16'd3, 16'd4, 1'b1, 1'b0);
        drive(16'hFFFE, 16'd5, 1'b1, 1'b0);
        drive(16'd7, 16'd7, 1'b1, 1'b1);
        drive(16'd0, 16'd0, 1'b0, 1'b0);
        cycles(9);
        chk("dot3_not_yet", {63'd0, out_valid}, 64'd0);
        chk("dot3_busy", {63'd0, busy}, 64'd1);
        cycles(1);
        chk("dot3_valid", {63'd0, out_valid}, 64'd1);
        chk("dot3_acc",   {24'd0, out_acc}, 64'd51);
        chk("dot3_count", {56'd0, out_count}, 64'd3);
        chk("dot3_ovf",   {63'd0, out_ovf}, 64'd0);
        cycles(1);
        chk("dot3_consumed", {63'd0, out_valid}, 64'd0);

        // (-1)*(-1) single-term group
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        drive(16'd0, 16'd0, 1'b0, 1'b0);
        wait_out(20, "neg1_timeout");
        chk("neg1_acc",   {24'd0, out_acc}, 64'd1);
        chk("neg1_count", {56'd0, out_count}, 64'd1);
        cycles(2);

        // 512 * 2^30 = 2^39 overflows a 40-bit signed accumulator on the last term
        for (int i = 0; i < 512; i++) drive(16'h8000, 16'h8000, 1'b1, (i == 511));
        drive(16'd0, 16'd0, 1'b0, 1'b0);
        wait_out(20, "big_timeout");
`ifdef DADDA_MAC_SAT_EN
        big_exp = 40'h7FFFFFFFFF;
`else
        big_exp = 40'h8000000000;
`endif
        chk("big_acc",   {24'd0, out_acc}, {24'd0, big_exp});
        chk("big_count", {56'd0, out_count}, 64'd255);
        chk("big_ovf",   {63'd0, out_ovf}, 64'd1);
        cycles(2);

        // second result completes exactly when the first is accepted
        out_ready = 1'b0;
        drive(16'd2, 16'd2, 1'b1, 1'b1);
        drive(16'd3, 16'd3, 1'b1, 1'b1);
        drive(16'd0, 16'd0, 1'b0, 1'b0);
        cycles(8);
        chk("repl_not_yet", {63'd0, out_valid}, 64'd0);
        cycles(1);
        chk("repl_first_valid", {63'd0, out_valid}, 64'd1);
        chk("repl_first_acc", {24'd0, out_acc}, 64'd4);
        out_ready = 1'b1;
        cycles(1);
        chk("repl_second_valid", {63'd0, out_valid}, 64'd1);
        chk("repl_second_acc", {24'd0, out_acc}, 64'd9);
        chk("repl_overrun", {63'd0, overrun}, 64'd0);
        cycles(1);
        chk("repl_drained", {63'd0, out_valid}, 64'd0);

        // back-to-back 1-term groups with the consumer stalled
        out_ready = 1'b0;
        drive(16'd5, 16'd5, 1'b1, 1'b1);
        drive(16'd6, 16'd6, 1'b1, 1'b1);
        drive(16'd0, 16'd0, 1'b0, 1'b0);
        wait_out(20, "ovr_timeout");
        chk("ovr_first_acc", {24'd0, out_acc}, 64'd25);
        cycles(3);
        chk("ovr_overrun", {63'd0, overrun}, 64'd1);
        chk("ovr_held_acc", {24'd0, out_acc}, 64'd25);
        chk("ovr_held_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        cycles(1);
        chk("ovr_accepted", {63'd0, out_valid}, 64'd0);
        chk("ovr_sticky", {63'd0, overrun}, 64'd1);

        // reset mid-flight discards the four issued terms
        drive(16'd1, 16'd1, 1'b1, 1'b0);
        drive(16'd1, 16'd1, 1'b1, 1'b0);
        drive(16'd1, 16'd1, 1'b1, 1'b0);
        drive(16'd1, 16'd1, 1'b1, 1'b1);
        drive(16'd0, 16'd0, 1'b0, 1'b0);
        cycles(1);
        chk("mid_busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        chk("mid_busy_after", {63'd0, busy}, 64'd0);
        chk("mid_overrun_cleared", {63'd0, overrun}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            seen = seen | out_valid;
            cycles(1);
        end
        chk("mid_no_result", {63'd0, seen}, 64'd0);
        drive(16'd2, 16'd3, 1'b1, 1'b1);
        drive(16'd0, 16'd0, 1'b0, 1'b0);
        wait_out(20, "post_timeout");
        chk("post_acc",   {24'd0, out_acc}, 64'd6);
        chk("post_count", {56'd0, out_count}, 64'd1);
        cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
